shift_out_driver: RTL



---
 rtl/shift_out_driver.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_out_driver.sv
// Writer for a daisy-chained 74HC595 chain: shifts a WIDTH-bit word out on DS/SHCP,
// latches it with one STCP pulse, or clears the chain through MR_BAR.
module shift_out_driver #(
    parameter int WIDTH     = 128,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CLEAR,
    input  logic [WIDTH-1:0] DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             DS,
    output logic             SHCP,
    output logic             STCP,
    output logic             MR_BAR
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, SH_LO, SH_HI, LATCH, CLR, CLR_LATCH, FIN} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic               div_done, last_bit, cur_bit;
    logic               busy_c, done_c, ds_c, shcp_c, stcp_c, mr_bar_c;

    assign div_done = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    assign cur_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Divider restarts on every state change so each phase lasts exactly CLK_DIV cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (state_nxt != state || div_done) div_cnt <= '0;
            else                                div_cnt <= div_cnt + 1'b1;
            if (state == IDLE)                  bit_cnt <= '0;
            else if (state == SH_HI && div_done) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE && state_nxt == SH_LO)
            shreg <= DATA;
        else if (state == SH_HI && div_done)
            shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (CLEAR) state_nxt = CLR;
                       else if (START) state_nxt = SH_LO;
            SH_LO:     if (div_done) state_nxt = SH_HI;
            SH_HI:     if (div_done) state_nxt = last_bit ? LATCH : SH_LO;
            LATCH:     if (div_done) state_nxt = FIN;
            CLR:       if (div_done) state_nxt = CLR_LATCH;
            CLR_LATCH: if (div_done) state_nxt = FIN;
            FIN:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c   = 1'b0;
        done_c   = 1'b0;
        ds_c     = 1'b0;
        shcp_c   = 1'b0;
        stcp_c   = 1'b0;
        mr_bar_c = 1'b1;
        case (state)
            SH_LO:     begin busy_c = 1'b1; ds_c = cur_bit; end
            SH_HI:     begin busy_c = 1'b1; ds_c = cur_bit; shcp_c = 1'b1; end
            LATCH:     begin busy_c = 1'b1; stcp_c = 1'b1; end
            CLR:       begin busy_c = 1'b1; mr_bar_c = 1'b0; end
            CLR_LATCH: begin busy_c = 1'b1; stcp_c = 1'b1; end
            FIN:       done_c = 1'b1;
            default:   ;
        endcase
    end

    // Output register: pins follow the state one cycle later, glitch-free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            DS     <= 1'b0;
            SHCP   <= 1'b0;
            STCP   <= 1'b0;
            MR_BAR <= 1'b1;
        end else begin
            BUSY   <= busy_c;
            DONE   <= done_c;
            DS     <= ds_c;
            SHCP   <= shcp_c;
            STCP   <= stcp_c;
            MR_BAR <= mr_bar_c;
        end
    end

endmodule
